// File: rtl/fpcvt_defs.sv
// Shared widths, limits and FSM encodings for the lab floating-point converter.
package fpcvt_defs;

  localparam int IN_W       = 12;
  localparam int EXP_W      = 3;
  localparam int SIG_W      = 4;
  localparam int MAG_W      = IN_W - 1;

  localparam int EXP_MAX    = 7;
  localparam int SIG_MAX    = 15;
  localparam int SIG_RENORM = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
  } fp_ef_t;

endpackage

// File: rtl/convert2toSM.sv
// Combinational two's-complement to sign-magnitude converter.
module convert2toSM
  import fpcvt_defs::*;
(
  input  logic signed [IN_W-1:0] d,
  output logic                   sgn,
  output logic [MAG_W-1:0]       mag
);

  logic [IN_W-1:0] neg;

  assign neg = -d;

  // The most negative input has no 11-bit magnitude, so it clamps to all ones.
  always_comb begin
    sgn = d[IN_W-1];
    if (!d[IN_W-1])
      mag = d[MAG_W-1:0];
    else if (neg[IN_W-1])
      mag = '1;
    else
      mag = neg[MAG_W-1:0];
  end

endmodule

// File: rtl/fpcvt_seq_ctrl.sv
// Sequential two's-complement to sign/exponent/significand converter with
// one normalising shift per cycle and a start/busy/done handshake.
module fpcvt_seq_ctrl #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [IN_W-1:0] d,
  output logic                   busy,
  output logic                   done,
  output logic                   s,
  output logic [EXP_W-1:0]       e,
  output logic [SIG_W-1:0]       f
);
  import fpcvt_defs::*;

  localparam int M_W = IN_W - 1;

  logic [1:0]       state;
  logic             s_reg;
  logic [M_W-1:0]   m_reg;
  logic [EXP_W-1:0] e_cnt;
  logic             cv_sgn;
  logic [M_W-1:0]   cv_mag;
  fp_ef_t           rnd;

  convert2toSM u_cvt (
    .d   (d),
    .sgn (cv_sgn),
    .mag (cv_mag)
  );

  // top = {fr, rb}; carries out of f and e steer renormalise vs saturate
  function automatic fp_ef_t round_res(input logic [SIG_W:0]   top,
                                       input logic [EXP_W-1:0] ec);
    fp_ef_t         r;
    logic [SIG_W:0] f_inc;
    logic [EXP_W:0] e_inc;
    f_inc = {1'b0, top[SIG_W:1]} + {{SIG_W{1'b0}}, 1'b1};
    e_inc = {1'b0, ec} + {{EXP_W{1'b0}}, 1'b1};
    if (!top[0]) begin
      r.e = ec;
      r.f = top[SIG_W:1];
    end else if (!f_inc[SIG_W]) begin
      r.e = ec;
      r.f = f_inc[SIG_W-1:0];
    end else if (!e_inc[EXP_W]) begin
      r.e = e_inc[EXP_W-1:0];
      r.f = SIG_W'(SIG_RENORM);
    end else begin
      r.e = EXP_W'(EXP_MAX);
      r.f = SIG_W'(SIG_MAX);
    end
    return r;
  endfunction

  assign rnd = round_res(m_reg[M_W-1 -: SIG_W+1], e_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= 1'b0;
      e     <= '0;
      f     <= '0;
      s_reg <= 1'b0;
      m_reg <= '0;
      e_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            s_reg <= cv_sgn;
            m_reg <= cv_mag;
            e_cnt <= EXP_W'(EXP_MAX);
            busy  <= 1'b1;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (m_reg[M_W-1] || e_cnt == '0) begin
            state <= ST_ROUND;
          end else begin
            m_reg <= m_reg << 1;
            e_cnt <= e_cnt - 1'b1;
          end
        end
        ST_ROUND: begin
          s     <= s_reg;
          e     <= rnd.e;
          f     <= rnd.f;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Scoreboard bench for fpcvt_seq_ctrl: directed corner cases plus random operands.
module tb_fpcvt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] d = 12'd0;
  logic        busy, done, s;
  logic [2:0]  e;
  logic [3:0]  f;

  fpcvt_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .e     (e),
    .f     (f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    int         acc;
    int         due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   next_free = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: normalise |d| by doubling until it reaches 1024 (at most 7 times),
  // then round to 4 significant bits on the next bit down.
  function automatic void model(input logic [11:0] dv, output logic ms,
                                output logic [2:0] me, output logic [3:0] mf,
                                output int lat);
    int v, mag, k, sc, fr, rb, ex;
    v   = int'($signed(dv));
    ms  = (v < 0);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    k = 0;
    while (k < 7 && (mag << k) < 1024) k++;
    sc = mag << k;
    fr = sc / 128;
    rb = (sc / 64) % 2;
    ex = 7 - k;
    if (rb == 1) begin
      if (fr < 15) fr++;
      else if (ex < 7) begin
        ex++;
        fr = 8;
      end else fr = 15;
    end
    me  = ex[2:0];
    mf  = fr[3:0];
    lat = k + 2;
  endfunction

  task automatic issue(input logic [11:0] dv, input bit hold);
    logic       ms;
    logic [2:0] me;
    logic [3:0] mf;
    int         lat, acc;
    @(negedge clk);
    model(dv, ms, me, mf, lat);
    acc = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    sbq.push_back('{ms, me, mf, acc, acc + lat});
    next_free = acc + lat + 1;
    start = 1'b1;
    d     = dv;
    while (cyc < acc) @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic poke(input logic [11:0] dv);
    @(negedge clk);
    start = 1'b1;
    d     = dv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s"}, s, 0);
    check({tag, "_e"}, e, 0);
    check({tag, "_f"}, f, 0);
  endtask

  exp_t x;
  logic exp_busy;

  // Monitor: busy against the accepted-operation windows, results on done.
  always @(negedge clk) begin
    if (!rst) begin
      exp_busy = 1'b0;
      foreach (sbq[i]) if (sbq[i].acc <= cyc && cyc < sbq[i].due) exp_busy = 1'b1;
      check("busy", busy, exp_busy);
      if (done) begin
        if (sbq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          x = sbq.pop_front();
          check("result_sef", {s, e, f}, {x.s, x.e, x.f});
          check("latency", cyc - x.acc, x.due - x.acc);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        x = sbq.pop_front();
        check("done_missing", 0, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [11:0] dv;
    bit          hold;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;

    issue(12'd422, 0);
    issue(12'd46, 0);
    issue(12'd1016, 0);
    issue(12'h800, 0);
    issue(12'hFFF, 0);
    issue(12'h000, 0);
    drain();

    // start pulse while busy must be dropped
    issue(12'd46, 0);
    @(negedge clk);
    poke(12'd1016);
    drain();
    repeat (3) @(negedge clk);

    // start held high: second accept lands in the done cycle
    issue(12'd422, 1);
    issue(12'd1016, 0);
    drain();

    // asynchronous reset in the middle of normalisation
    issue(12'd46, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    sbq.delete();
    next_free = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(12'd422, 0);
    drain();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       dv = 12'h800;
        1:       dv = 12'(1 << $urandom_range(0, 11));
        2:       dv = 12'($urandom_range(0, 15));
        default: dv = 12'($urandom);
      endcase
      hold = bit'($urandom_range(0, 1));
      issue(dv, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    issue(12'd999, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
